// File: rtl/cnn_pkg.sv
// Shared constants and encodings for the conv1 inference sequencer.
package cnn_pkg;

  localparam int DATA_WIDTH = 16;

  localparam int IMG_WORDS  = 784;
  localparam int WGT_WORDS  = 50;
  localparam int BIAS_WORDS = 2;
  localparam int MAP_WORDS  = 1152;

  localparam int IMG_AW  = $clog2(IMG_WORDS);
  localparam int WGT_AW  = $clog2(WGT_WORDS);
  localparam int BIAS_AW = $clog2(BIAS_WORDS);
  localparam int MAP_AW  = $clog2(MAP_WORDS);

  // Tag carried alongside ROM read data so that the output port is chosen
  // by where the data came from, not by the state at the time it arrives.
  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_IMG,
    TAG_WGT,
    TAG_BIAS
  } phase_tag_t;

endpackage

// File: rtl/edge_capture.sv
// Rising-edge detector for the layer's result and finish strobes, plus the
// feature-map buffer write port with its address counter and overflow flag.
module edge_capture
  import cnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  result_valid,
  input  logic                  finish_conv1,
  input  logic [DATA_WIDTH-1:0] map,
  output logic                  fmap_we,
  output logic [MAP_AW-1:0]     fmap_addr,
  output logic [DATA_WIDTH-1:0] fmap_wdata,
  output logic [MAP_AW:0]       count,
  output logic                  finish_rise,
  output logic                  overflow
);

  logic rv_q;
  logic fin_q;
  logic rv_rise;
  logic room;
  logic accept;

  // Edge detection, room check and write acceptance. The address counter
  // lags a write by one cycle, so the in-flight write is added back in.
  always_comb begin
    rv_rise     = enable & result_valid & ~rv_q;
    finish_rise = enable & finish_conv1 & ~fin_q;
    count       = {1'b0, fmap_addr} + (MAP_AW + 1)'(fmap_we);
    room        = (count < (MAP_AW + 1)'(MAP_WORDS));
    accept      = (rv_rise | finish_rise) & room;
    overflow    = rv_rise & ~room;
  end

  // Strobe history, write port registers and post-write address increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv_q       <= 1'b0;
      fin_q      <= 1'b0;
      fmap_we    <= 1'b0;
      fmap_addr  <= '0;
      fmap_wdata <= '0;
    end else begin
      rv_q  <= result_valid;
      fin_q <= finish_conv1;
      if (clear) begin
        fmap_we   <= 1'b0;
        fmap_addr <= '0;
      end else begin
        fmap_we <= accept;
        if (accept) begin
          fmap_wdata <= map;
        end
        if (fmap_we) begin
          fmap_addr <= fmap_addr + MAP_AW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv1_sequencer.sv
// Drives one pass of conv_layer_1: kick, stream image/weight/bias ROM words,
// capture the emitted feature map and report done or error.
module conv1_sequencer
  import cnn_pkg::*;
#(
  parameter int TIMEOUT = 200000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IMG_AW-1:0]     img_addr,
  input  logic [DATA_WIDTH-1:0] img_rdata,
  output logic [WGT_AW-1:0]     wgt_addr,
  input  logic [DATA_WIDTH-1:0] wgt_rdata,
  output logic [BIAS_AW-1:0]    bias_addr,
  input  logic [DATA_WIDTH-1:0] bias_rdata,
  output logic                  start_conv1,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] partial_image_in,
  output logic [DATA_WIDTH-1:0] partial_weights_in,
  output logic [DATA_WIDTH-1:0] partial_biases_in,
  input  logic                  finish_conv1,
  input  logic                  result_valid,
  input  logic [DATA_WIDTH-1:0] map,
  output logic                  fmap_we,
  output logic [MAP_AW-1:0]     fmap_addr,
  output logic [DATA_WIDTH-1:0] fmap_wdata
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    S_IMG,
    S_WGT,
    S_BIAS,
    WAIT,
    FIN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IMG_AW-1:0] cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  phase_tag_t        issue_tag;
  phase_tag_t        tag_q;
  logic              issue;
  logic              last_word;
  logic              accept_start;
  logic              timeout_hit;
  logic              fin_bad;
  logic              cap_enable;
  logic [MAP_AW:0]   cap_count;
  logic              finish_rise;
  logic              overflow;

  edge_capture u_capture (
    .clk          (clk),
    .reset        (reset),
    .clear        (accept_start),
    .enable       (cap_enable),
    .result_valid (result_valid),
    .finish_conv1 (finish_conv1),
    .map          (map),
    .fmap_we      (fmap_we),
    .fmap_addr    (fmap_addr),
    .fmap_wdata   (fmap_wdata),
    .count        (cap_count),
    .finish_rise  (finish_rise),
    .overflow     (overflow)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, read issue and status outputs.
  always_comb begin
    state_nxt    = state;
    issue        = 1'b0;
    last_word    = 1'b0;
    issue_tag    = TAG_NONE;
    timeout_hit  = 1'b0;
    fin_bad      = 1'b0;
    done         = 1'b0;
    accept_start = 1'b0;
    img_addr     = '0;
    wgt_addr     = '0;
    bias_addr    = '0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = KICK;
        end
      end
      KICK: state_nxt = S_IMG;
      S_IMG: begin
        issue     = ~pause;
        issue_tag = TAG_IMG;
        img_addr  = cnt;
        last_word = (cnt == IMG_AW'(IMG_WORDS - 1));
        if (issue && last_word) state_nxt = S_WGT;
      end
      S_WGT: begin
        issue     = ~pause;
        issue_tag = TAG_WGT;
        wgt_addr  = cnt[WGT_AW-1:0];
        last_word = (cnt == IMG_AW'(WGT_WORDS - 1));
        if (issue && last_word) state_nxt = S_BIAS;
      end
      S_BIAS: begin
        issue     = ~pause;
        issue_tag = TAG_BIAS;
        bias_addr = cnt[BIAS_AW-1:0];
        last_word = (cnt == IMG_AW'(BIAS_WORDS - 1));
        if (issue && last_word) state_nxt = WAIT;
      end
      WAIT: begin
        if (finish_rise) begin
          state_nxt = FIN;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      FIN: begin
        done      = (cap_count == (MAP_AW + 1)'(MAP_WORDS));
        fin_bad   = ~done;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stream counter, timeout counter, sticky error and the read-data tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      tmo_cnt    <= '0;
      error      <= 1'b0;
      data_valid <= 1'b0;
      tag_q      <= TAG_NONE;
    end else begin
      data_valid <= issue;
      tag_q      <= issue ? issue_tag : TAG_NONE;
      if (accept_start) begin
        cnt     <= '0;
        tmo_cnt <= '0;
        error   <= 1'b0;
      end else begin
        if (issue) begin
          cnt <= last_word ? '0 : cnt + IMG_AW'(1);
        end
        if (state == WAIT) begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        if (overflow || timeout_hit || fin_bad) begin
          error <= 1'b1;
        end
      end
    end
  end

  // Route returning ROM data to the port named by its tag; others stay 0.
  always_comb begin
    busy               = (state != IDLE);
    start_conv1        = (state == KICK);
    cap_enable         = (state != IDLE);
    partial_image_in   = (data_valid && tag_q == TAG_IMG)  ? img_rdata  : '0;
    partial_weights_in = (data_valid && tag_q == TAG_WGT)  ? wgt_rdata  : '0;
    partial_biases_in  = (data_valid && tag_q == TAG_BIAS) ? bias_rdata : '0;
  end

endmodule
